// File: rtl/traffic_pkg.sv
// Shared definitions for the lamp output path: FSM states, approach indices,
// direction masks, lamp colour codes and the green-set legality rule.
package traffic_pkg;

  typedef enum logic [2:0] {IDLE, YELLOW, ALLRED, APPLY, FLASH} state_t;

  localparam int APP_N = 0;
  localparam int APP_E = 1;
  localparam int APP_S = 2;
  localparam int APP_W = 3;

  localparam logic [3:0] NS_MASK = 4'b0101;
  localparam logic [3:0] EW_MASK = 4'b1010;

  typedef enum logic [1:0] {LAMP_RED = 2'd0, LAMP_YELLOW = 2'd1, LAMP_GREEN = 2'd2} lamp_color_t;

  // A green set is safe when it stays within one axis; the empty set is all-red.
  function automatic logic green_set_legal(input logic [3:0] g);
    return ((g & ~NS_MASK) == 4'b0000) || ((g & ~EW_MASK) == 4'b0000);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Down-counter shared by all timed phases: loaded with N-1 on phase entry,
// expired while the count sits at zero.
module phase_timer #(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          tick,
  output logic          expired
);

  logic [TW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - TW'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/lamp_output_driver.sv
// Drives the four approach lamps with green->yellow->all-red->green sequencing.
// Optional failsafe flash on illegal requests: define FLASH_FAILSAFE_EN.
//   state  | meaning
//   IDLE   | lamps steady, ready for a new green set
//   YELLOW | dropped greens show yellow for YELLOW_TIME cycles
//   ALLRED | all approaches red for ALLRED_TIME cycles
//   APPLY  | one cycle; pending green set is loaded onto the lamps at its end
//   FLASH  | failsafe: all red lamps blink, latched until reset
import traffic_pkg::*;

module lamp_output_driver #(
  parameter int YELLOW_TIME  = 4,
  parameter int ALLRED_TIME  = 2,
  parameter int FLASH_PERIOD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [3:0] req_green,
  output logic       req_ready,
  output logic [3:0] lamp_r,
  output logic [3:0] lamp_y,
  output logic [3:0] lamp_g,
  output logic       busy,
  output logic       fault
);

  localparam int TW = $clog2(max3(YELLOW_TIME, ALLRED_TIME, FLASH_PERIOD) + 1);

  state_t        state, state_nxt;
  logic [3:0]    cur_green, cur_nxt, pend_green, pend_nxt;
  logic [3:0]    r_nxt, y_nxt, g_nxt, drop;
  logic          fault_nxt, accept, tmr_load, tmr_expired;
  logic [TW-1:0] tmr_val;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;
  assign drop      = cur_green & ~req_green;

  phase_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (1'b1),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur_green;
    pend_nxt  = pend_green;
    r_nxt     = lamp_r;
    y_nxt     = lamp_y;
    g_nxt     = lamp_g;
    fault_nxt = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          pend_nxt = req_green;
          if (!green_set_legal(req_green)) begin
            fault_nxt = 1'b1;
`ifdef FLASH_FAILSAFE_EN
            state_nxt = FLASH;
            r_nxt     = 4'hF;
            y_nxt     = 4'h0;
            g_nxt     = 4'h0;
            tmr_load  = 1'b1;
            tmr_val   = TW'(FLASH_PERIOD - 1);
`endif
          end else if (drop == 4'h0) begin
            state_nxt = APPLY;
          end else begin
            // Greens that stay requested keep running through the yellow phase.
            state_nxt = YELLOW;
            g_nxt     = cur_green & req_green;
            y_nxt     = drop;
            tmr_load  = 1'b1;
            tmr_val   = TW'(YELLOW_TIME - 1);
          end
        end
      end
      YELLOW: begin
        if (tmr_expired) begin
          state_nxt = ALLRED;
          r_nxt     = 4'hF;
          y_nxt     = 4'h0;
          g_nxt     = 4'h0;
          tmr_load  = 1'b1;
          tmr_val   = TW'(ALLRED_TIME - 1);
        end
      end
      ALLRED: begin
        if (tmr_expired) state_nxt = APPLY;
      end
      APPLY: begin
        g_nxt     = pend_green;
        r_nxt     = ~pend_green;
        y_nxt     = 4'h0;
        cur_nxt   = pend_green;
        state_nxt = IDLE;
      end
      FLASH: begin
`ifdef FLASH_FAILSAFE_EN
        if (tmr_expired) begin
          r_nxt    = ~lamp_r;
          tmr_load = 1'b1;
          tmr_val  = TW'(FLASH_PERIOD - 1);
        end
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lamp_r     <= 4'hF;
      lamp_y     <= 4'h0;
      lamp_g     <= 4'h0;
      cur_green  <= 4'h0;
      pend_green <= 4'h0;
      fault      <= 1'b0;
    end else begin
      state      <= state_nxt;
      lamp_r     <= r_nxt;
      lamp_y     <= y_nxt;
      lamp_g     <= g_nxt;
      cur_green  <= cur_nxt;
      pend_green <= pend_nxt;
      fault      <= fault_nxt;
    end
  end

endmodule
